// File: rtl/ex_ctrl_pkg.sv
// Shared types and helpers for the DLX execute-stage issue controller.
package ex_ctrl_pkg;

    localparam int CTRL_W = 7;

    localparam logic [2:0] OP_MEM_READ    = 3'b101;
    localparam logic [2:0] OP_MEM_WRITE   = 3'b100;
    localparam logic [2:0] OP_ARITH_LOGIC = 3'b001;
    localparam logic [2:0] OP_SHIFT_REG   = 3'b000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } ex_ctrl_state_t;

    // control = {operation[2:0], immp_regn, opselect[2:0]}
    function automatic logic is_load(input logic [CTRL_W-1:0] control);
        return (control[2:0] == OP_MEM_READ) && control[3];
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// Decode, execute-stage and data-memory signals of the issue controller.
interface ex_issue_ctrl_if
    import ex_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              dec_valid;
    logic              dec_ready;
    logic [CTRL_W-1:0] control_in;
    logic [31:0]       src1;
    logic [31:0]       src2;
    logic [31:0]       imm;
    logic              ex_stall;
    logic              enable_ex;
    logic [CTRL_W-1:0] control_out;
    logic [31:0]       src1_out;
    logic [31:0]       src2_out;
    logic [31:0]       imm_out;
    logic              mem_rd_req;
    logic              mem_rd_ack;
    logic [31:0]       mem_rd_data;
    logic [31:0]       ld_data;
    logic              err_timeout;
    logic [CNT_W-1:0]  issue_count;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output dec_valid, control_in, src1, src2, imm, ex_stall, mem_rd_ack, mem_rd_data,
        input  dec_ready, enable_ex, control_out, src1_out, src2_out, imm_out,
               mem_rd_req, ld_data, err_timeout, issue_count, stall_count
    );

    modport slave (
        input  dec_valid, control_in, src1, src2, imm, ex_stall, mem_rd_ack, mem_rd_data,
        output dec_ready, enable_ex, control_out, src1_out, src2_out, imm_out,
               mem_rd_req, ld_data, err_timeout, issue_count, stall_count
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + W'(1);
    end
endmodule

// File: rtl/ex_issue_ctrl.sv
// Holds one decoded instruction, strobes execute stage 1, and fetches load data
// from memory before issuing loads. Timeout lands in ERR until reset.
module ex_issue_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    ex_issue_ctrl_if.slave bus
);
    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    ex_ctrl_state_t    state, state_nxt;
    logic [WC_W-1:0]   wait_cnt;
    logic [CTRL_W-1:0] ctrl_q;
    logic [31:0]       src1_q, src2_q, imm_q, ld_q;
    logic              dec_ready, enable_ex, mem_rd_req, err_timeout;
    logic              accept, stall_inc;

    assign accept = bus.dec_valid && dec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (accept) state_nxt = is_load(bus.control_in) ? MEM_WAIT : ISSUE;
            ISSUE:
                if (!bus.ex_stall) begin
                    if (accept) state_nxt = is_load(bus.control_in) ? MEM_WAIT : ISSUE;
                    else        state_nxt = IDLE;
                end
            MEM_WAIT:
                // an ack in the last allowed cycle still beats the timeout
                if (bus.mem_rd_ack)          state_nxt = ISSUE;
                else if (wait_cnt == WC_LAST) state_nxt = ERR;
            ERR:      state_nxt = ERR;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dec_ready   = 1'b0;
        enable_ex   = 1'b0;
        mem_rd_req  = 1'b0;
        err_timeout = 1'b0;
        case (state)
            IDLE:     dec_ready   = 1'b1;
            ISSUE: begin
                dec_ready = !bus.ex_stall;
                enable_ex = !bus.ex_stall;
            end
            MEM_WAIT: mem_rd_req  = 1'b1;
            ERR:      err_timeout = 1'b1;
            default:  dec_ready   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            imm_q    <= '0;
            ld_q     <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                ctrl_q <= bus.control_in;
                src1_q <= bus.src1;
                src2_q <= bus.src2;
                imm_q  <= bus.imm;
            end
            if (state == MEM_WAIT && bus.mem_rd_ack)
                ld_q <= bus.mem_rd_data;
            // held at zero outside MEM_WAIT so every wait starts from a clean count
            if (state != MEM_WAIT)
                wait_cnt <= '0;
            else if (!bus.mem_rd_ack && wait_cnt != WC_LAST)
                wait_cnt <= wait_cnt + WC_W'(1);
        end
    end

    assign stall_inc = (state == MEM_WAIT) || (state == ISSUE && bus.ex_stall);

    sat_counter #(.W(CNT_W)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .inc (enable_ex),
        .q   (bus.issue_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (bus.stall_count)
    );

    assign bus.dec_ready   = dec_ready;
    assign bus.enable_ex   = enable_ex;
    assign bus.mem_rd_req  = mem_rd_req;
    assign bus.err_timeout = err_timeout;
    assign bus.control_out = ctrl_q;
    assign bus.src1_out    = src1_q;
    assign bus.src2_out    = src2_q;
    assign bus.imm_out     = imm_q;
    assign bus.ld_data     = ld_q;
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl: one 16-bit-counter instance, one 3-bit
// instance for saturation.
module tb_ex_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ex_issue_ctrl_if #(.CNT_W(16)) ifa ();
    ex_issue_ctrl_if #(.CNT_W(3))  ifb ();

    ex_issue_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    ex_issue_ctrl #(.MEM_TIMEOUT(16), .CNT_W(3))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    localparam logic [6:0] LD_CTL = 7'h0D;  // op 0, immp_regn 1, MEM_READ

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] arith(input int i);
        logic [2:0] op;
        op = 3'(i);
        return {op, 1'b0, 3'b001};
    endfunction

    initial begin
        ifa.dec_valid = 0; ifa.control_in = '0; ifa.src1 = '0; ifa.src2 = '0; ifa.imm = '0;
        ifa.ex_stall = 0; ifa.mem_rd_ack = 0; ifa.mem_rd_data = '0;
        ifb.dec_valid = 0; ifb.control_in = '0; ifb.src1 = '0; ifb.src2 = '0; ifb.imm = '0;
        ifb.ex_stall = 0; ifb.mem_rd_ack = 0; ifb.mem_rd_data = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ifa.dec_ready), 32'd1);
        chk("rst_en",    32'(ifa.enable_ex), 32'd0);
        chk("rst_req",   32'(ifa.mem_rd_req), 32'd0);
        chk("rst_err",   32'(ifa.err_timeout), 32'd0);
        chk("rst_ld",    ifa.ld_data, 32'd0);
        chk("rst_ctl",   32'(ifa.control_out), 32'd0);
        chk("rst_issue", 32'(ifa.issue_count), 32'd0);
        chk("rst_stall", 32'(ifa.stall_count), 32'd0);
        rst = 0;

        // back-to-back non-loads
        ifa.dec_valid = 1; ifa.control_in = arith(0); ifa.src1 = 32'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                ifa.control_in = arith(i + 1);
                ifa.src1 = 32'(i + 2);
            end else begin
                ifa.dec_valid = 0;
            end
            @(negedge clk);
            chk("b2b_en",   32'(ifa.enable_ex), 32'd1);
            chk("b2b_ctl",  32'(ifa.control_out), 32'(arith(i)));
            chk("b2b_src1", ifa.src1_out, 32'(i + 1));
        end
        @(posedge clk); @(negedge clk);
        chk("b2b_idle_en", 32'(ifa.enable_ex), 32'd0);
        chk("b2b_issue",   32'(ifa.issue_count), 32'd4);

        // load, ack during the 4th wait cycle
        ifa.control_in = LD_CTL; ifa.src1 = 32'h10; ifa.dec_valid = 1;
        @(posedge clk); #1 ifa.dec_valid = 0;
        @(negedge clk);
        chk("ld_req",   32'(ifa.mem_rd_req), 32'd1);
        chk("ld_rdy",   32'(ifa.dec_ready), 32'd0);
        chk("ld_en",    32'(ifa.enable_ex), 32'd0);
        chk("ld_src1",  ifa.src1_out, 32'h10);
        repeat (3) @(posedge clk);
        #1 ifa.mem_rd_ack = 1; ifa.mem_rd_data = 32'hDEADBEEF;
        @(posedge clk); #1 ifa.mem_rd_ack = 0; ifa.mem_rd_data = '0;
        @(negedge clk);
        chk("ld_data",  ifa.ld_data, 32'hDEADBEEF);
        chk("ld_issue", 32'(ifa.enable_ex), 32'd1);
        chk("ld_req_off", 32'(ifa.mem_rd_req), 32'd0);
        chk("ld_stall", 32'(ifa.stall_count), 32'd4);
        @(posedge clk); @(negedge clk);
        chk("ld_en_off", 32'(ifa.enable_ex), 32'd0);
        chk("ld_icnt",   32'(ifa.issue_count), 32'd5);

        // stray ack while idle
        ifa.mem_rd_ack = 1; ifa.mem_rd_data = 32'h12345678;
        @(posedge clk); #1 ifa.mem_rd_ack = 0; ifa.mem_rd_data = '0;
        @(negedge clk);
        chk("stray_ack", ifa.ld_data, 32'hDEADBEEF);
        chk("stray_rdy", 32'(ifa.dec_ready), 32'd1);

        // 5-cycle stall in ISSUE, hold registers frozen
        ifa.ex_stall = 1; ifa.control_in = arith(5); ifa.src1 = 32'h55; ifa.dec_valid = 1;
        @(posedge clk); #1 ifa.control_in = arith(6); ifa.src1 = 32'h99;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stl_en",   32'(ifa.enable_ex), 32'd0);
            chk("stl_rdy",  32'(ifa.dec_ready), 32'd0);
            chk("stl_hold", ifa.src1_out, 32'h55);
            @(posedge clk);
        end
        #1 ifa.ex_stall = 0; ifa.dec_valid = 0;
        @(negedge clk);
        chk("stl_go",    32'(ifa.enable_ex), 32'd1);
        chk("stl_src1",  ifa.src1_out, 32'h55);
        chk("stl_cnt",   32'(ifa.stall_count), 32'd9);
        @(posedge clk); @(negedge clk);
        chk("stl_icnt",  32'(ifa.issue_count), 32'd6);

        // timeout: no ack for 16 wait cycles
        ifa.control_in = LD_CTL; ifa.dec_valid = 1;
        @(posedge clk); #1 ifa.dec_valid = 0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("to_pre_err", 32'(ifa.err_timeout), 32'd0);
        chk("to_pre_req", 32'(ifa.mem_rd_req), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("to_err",   32'(ifa.err_timeout), 32'd1);
        chk("to_rdy",   32'(ifa.dec_ready), 32'd0);
        chk("to_req",   32'(ifa.mem_rd_req), 32'd0);
        chk("to_stall", 32'(ifa.stall_count), 32'd25);
        ifa.dec_valid = 1; ifa.control_in = arith(2); ifa.mem_rd_ack = 1; ifa.mem_rd_data = 32'h0BAD0BAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("to_sticky", 32'(ifa.err_timeout), 32'd1);
        chk("to_en",     32'(ifa.enable_ex), 32'd0);
        chk("to_icnt",   32'(ifa.issue_count), 32'd6);
        chk("to_ld",     ifa.ld_data, 32'hDEADBEEF);
        ifa.dec_valid = 0; ifa.mem_rd_ack = 0; ifa.mem_rd_data = '0;
        rst = 1; #1;
        chk("to_rst_err", 32'(ifa.err_timeout), 32'd0);
        chk("to_rst_rdy", 32'(ifa.dec_ready), 32'd1);
        @(negedge clk) rst = 0;

        // ack in exactly the 16th wait cycle
        ifa.control_in = LD_CTL; ifa.src1 = 32'h20; ifa.dec_valid = 1;
        @(posedge clk); #1 ifa.dec_valid = 0;
        repeat (15) @(posedge clk);
        #1 ifa.mem_rd_ack = 1; ifa.mem_rd_data = 32'hCAFEF00D;
        @(negedge clk);
        chk("last_pre_err", 32'(ifa.err_timeout), 32'd0);
        chk("last_pre_req", 32'(ifa.mem_rd_req), 32'd1);
        @(posedge clk); #1 ifa.mem_rd_ack = 0; ifa.mem_rd_data = '0;
        @(negedge clk);
        chk("last_err",   32'(ifa.err_timeout), 32'd0);
        chk("last_ld",    ifa.ld_data, 32'hCAFEF00D);
        chk("last_en",    32'(ifa.enable_ex), 32'd1);
        chk("last_stall", 32'(ifa.stall_count), 32'd16);
        @(posedge clk); @(negedge clk);
        chk("last_icnt",  32'(ifa.issue_count), 32'd1);
        chk("last_rdy",   32'(ifa.dec_ready), 32'd1);

        // reset three cycles into a wait drops the request immediately
        ifa.control_in = LD_CTL; ifa.dec_valid = 1;
        @(posedge clk); #1 ifa.dec_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_req", 32'(ifa.mem_rd_req), 32'd1);
        rst = 1; #1;
        chk("mid_req_drop", 32'(ifa.mem_rd_req), 32'd0);
        chk("mid_rdy",      32'(ifa.dec_ready), 32'd1);
        chk("mid_ld",       ifa.ld_data, 32'd0);
        @(negedge clk) rst = 0;
        @(posedge clk); @(negedge clk);
        chk("mid_post_rdy",   32'(ifa.dec_ready), 32'd1);
        chk("mid_post_req",   32'(ifa.mem_rd_req), 32'd0);
        chk("mid_post_issue", 32'(ifa.issue_count), 32'd0);
        chk("mid_post_stall", 32'(ifa.stall_count), 32'd0);

        // 3-bit counter: 9 issues saturate at 7
        ifb.control_in = arith(1); ifb.dec_valid = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sat_mid", 32'(ifb.issue_count), 32'd4);
        repeat (4) @(posedge clk);
        #1 ifb.dec_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", 32'(ifb.issue_count), 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
